// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the pc_sequencer fetch controller.
//   - pc_state_e : FSM state encoding (BOOT, RUN, FLUSH, HALT)
//   - PC_W_DEF, RESET_PC_DEF, FLUSH_CYCLES_DEF : parameter defaults
//   - sat_inc16  : saturating 16-bit increment used by the optional
//                  performance counters (PC_SEQ_PERF_EN)
package pc_seq_pkg;

  localparam int PC_W_DEF         = 9;
  localparam int RESET_PC_DEF     = 0;
  localparam int FLUSH_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } pc_state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    logic [15:0] res;
    if (val == 16'hFFFF) begin
      res = val;
    end else begin
      res = val + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// pc_seq_if: control/address bundle of the fetch-stage sequencer.
//   Inputs to the sequencer : stall, br_taken, br_target, halt_req, resume
//   Outputs of the sequencer: imem_addr, fetch_valid, pipe_en,
//                             flush_ifid, flush_idex, halted
//   With PC_SEQ_PERF_EN defined it also carries stall_cnt / redirect_cnt.
//   modport slave  : the sequencer side
//   modport master : the environment (hazard unit, EX, imem) side
interface pc_seq_if
  import pc_seq_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
);
  logic            stall;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            halt_req;
  logic            resume;
  logic [PC_W-1:0] imem_addr;
  logic            fetch_valid;
  logic            pipe_en;
  logic            flush_ifid;
  logic            flush_idex;
  logic            halted;
`ifdef PC_SEQ_PERF_EN
  logic [15:0]     stall_cnt;
  logic [15:0]     redirect_cnt;
`endif

  modport slave (
    input  stall, br_taken, br_target, halt_req, resume,
    output imem_addr, fetch_valid, pipe_en, flush_ifid, flush_idex, halted
`ifdef PC_SEQ_PERF_EN
    , output stall_cnt, redirect_cnt
`endif
  );

  modport master (
    output stall, br_taken, br_target, halt_req, resume,
    input  imem_addr, fetch_valid, pipe_en, flush_ifid, flush_idex, halted
`ifdef PC_SEQ_PERF_EN
    , input stall_cnt, redirect_cnt
`endif
  );

endinterface

// File: rtl/pc_incrementer.sv
// pc_incrementer: PC_W-bit +1 ripple adder; the carry out of the MSB is
// discarded so the result wraps from all-ones to zero.
//   pc_in  : current PC
//   pc_inc : pc_in + 1 modulo 2^PC_W
module pc_incrementer
  import pc_seq_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc_in,
  output logic [PC_W-1:0] pc_inc
);

  logic carry_s;

  // Half-adder chain seeded with a carry-in of one.
  always_comb begin
    carry_s = 1'b1;
    pc_inc  = '0;
    for (int i = 0; i < PC_W; i++) begin
      pc_inc[i] = pc_in[i] ^ carry_s;
      carry_s   = pc_in[i] & carry_s;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage controller owning the program counter.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : pc_seq_if.slave (stall/branch/halt/resume in; imem_addr,
//           fetch_valid, pipe_en, flush_ifid, flush_idex, halted out)
// Each cycle the PC increments, holds (stall / halt), or is redirected by a
// taken branch, after which the IF/ID and ID/EX flush strobes are held for
// FLUSH_CYCLES cycles. Optional macro PC_SEQ_PERF_EN adds saturating
// stall_cnt and redirect_cnt counters to the interface.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W         = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC     = PC_W'(RESET_PC_DEF),
  parameter int              FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     reset,
  pc_seq_if.slave  bus
);

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

  pc_state_e       state_r;
  logic [PC_W-1:0] pc_r;
  logic [1:0]      flush_cnt_r;
  logic [PC_W-1:0] pc_inc_s;
  logic            fetch_s;

  pc_incrementer #(.PC_W(PC_W)) u_inc (
    .pc_in  (pc_r),
    .pc_inc (pc_inc_s)
  );

  // Sequencer FSM: state, PC and flush counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= BOOT;
      pc_r        <= RESET_PC;
      flush_cnt_r <= 2'd0;
    end else begin
      case (state_r)
        BOOT: begin
          // First fetch uses RESET_PC itself, so no increment here.
          state_r <= RUN;
        end
        RUN: begin
          // Redirect beats halt, and a stall in the same cycle is dropped.
          if (bus.br_taken) begin
            pc_r        <= bus.br_target;
            state_r     <= FLUSH;
            flush_cnt_r <= FLUSH_INIT;
          end else if (bus.halt_req) begin
            state_r <= HALT;
          end else if (!bus.stall) begin
            pc_r <= pc_inc_s;
          end
        end
        FLUSH: begin
          // br_taken here comes from a squashed instruction and is ignored.
          if (!bus.stall) begin
            pc_r <= pc_inc_s;
          end
          if (flush_cnt_r <= 2'd1) begin
            flush_cnt_r <= 2'd0;
            state_r     <= RUN;
          end else begin
            flush_cnt_r <= flush_cnt_r - 2'd1;
          end
        end
        HALT: begin
          if (bus.resume) begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r     <= BOOT;
          pc_r        <= RESET_PC;
          flush_cnt_r <= 2'd0;
        end
      endcase
    end
  end

  assign fetch_s         = (state_r == RUN) || (state_r == FLUSH);
  assign bus.imem_addr   = pc_r;
  assign bus.fetch_valid = fetch_s;
  assign bus.pipe_en     = fetch_s & ~bus.stall;
  assign bus.flush_ifid  = (state_r == FLUSH) && (flush_cnt_r != 2'd0);
  assign bus.flush_idex  = (state_r == FLUSH) && (flush_cnt_r != 2'd0);
  assign bus.halted      = (state_r == HALT);

`ifdef PC_SEQ_PERF_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] redirect_cnt_r;

  // Saturating stall and accepted-redirect counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r    <= 16'd0;
      redirect_cnt_r <= 16'd0;
    end else begin
      if (fetch_s && bus.stall) begin
        stall_cnt_r <= sat_inc16(stall_cnt_r);
      end
      if ((state_r == RUN) && bus.br_taken) begin
        redirect_cnt_r <= sat_inc16(redirect_cnt_r);
      end
    end
  end

  assign bus.stall_cnt    = stall_cnt_r;
  assign bus.redirect_cnt = redirect_cnt_r;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer with a scoreboard.
// The driver applies one vector per cycle on the falling edge and queues the
// outputs expected for that cycle; a separate monitor pops and compares them
// shortly afterwards, before the next rising edge.
module tb_pc_sequencer;

  typedef struct packed {
    logic [8:0] addr;
    logic       fv;
    logic       pe;
    logic       fi;
    logic       fe;
    logic       h;
  } obs_t;

  logic clk;
  logic reset;

  obs_t  exp_q[$];
  string name_q[$];
  int    tests_run;
  int    tests_failed;

  pc_seq_if #(.PC_W(9)) bus ();

  pc_sequencer #(.PC_W(9), .RESET_PC(9'h000), .FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input logic rst, input logic st, input logic br,
                      input logic [8:0] tgt, input logic hr, input logic rs,
                      input logic [8:0] ea, input logic efv, input logic epe,
                      input logic efl, input logic eh, input string nm);
    obs_t e;
    @(negedge clk);
    reset         = rst;
    bus.stall     = st;
    bus.br_taken  = br;
    bus.br_target = tgt;
    bus.halt_req  = hr;
    bus.resume    = rs;
    e = '{addr: ea, fv: efv, pe: epe, fi: efl, fe: efl, h: eh};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare observed outputs against the queued expectation.
  initial begin
    obs_t  a;
    obs_t  e;
    string n;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = '{addr: bus.imem_addr, fv: bus.fetch_valid, pe: bus.pipe_en,
              fi: bus.flush_ifid, fe: bus.flush_idex, h: bus.halted};
        tests_run++;
        if (a !== e) begin
          tests_failed++;
          $display("FAIL %s: got addr=%h fv=%b pe=%b fi=%b fe=%b h=%b, expected addr=%h fv=%b pe=%b fi=%b fe=%b h=%b",
                   n, a.addr, a.fv, a.pe, a.fi, a.fe, a.h,
                   e.addr, e.fv, e.pe, e.fi, e.fe, e.h);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b0;
    bus.stall     = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = 9'h000;
    bus.halt_req  = 1'b0;
    bus.resume    = 1'b0;

    //   rst  st   br   tgt     hr   rs   addr    fv   pe   fl   h
    step(1'b0,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h000,1'b0,1'b0,1'b0,1'b0, "reset");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h000,1'b0,1'b0,1'b0,1'b0, "boot");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h000,1'b1,1'b1,1'b0,1'b0, "run0");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h001,1'b1,1'b1,1'b0,1'b0, "run1");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h002,1'b1,1'b1,1'b0,1'b0, "run2");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h003,1'b1,1'b1,1'b0,1'b0, "run3");
    // redirect near the top of the address space, then wrap in RUN
    step(1'b1,1'b0,1'b1,9'h1FD,1'b0,1'b0, 9'h004,1'b1,1'b1,1'b0,1'b0, "br_1fd");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h1FD,1'b1,1'b1,1'b1,1'b0, "flush_1fd");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h1FE,1'b1,1'b1,1'b1,1'b0, "flush_1fe");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h1FF,1'b1,1'b1,1'b0,1'b0, "run_1ff");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h000,1'b1,1'b1,1'b0,1'b0, "wrap_000");
    // get to 0x010, then redirect to 0x080 with ignored branches in FLUSH
    step(1'b1,1'b0,1'b1,9'h00E,1'b0,1'b0, 9'h001,1'b1,1'b1,1'b0,1'b0, "br_00e");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h00E,1'b1,1'b1,1'b1,1'b0, "flush_00e");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h00F,1'b1,1'b1,1'b1,1'b0, "flush_00f");
    step(1'b1,1'b0,1'b1,9'h080,1'b0,1'b0, 9'h010,1'b1,1'b1,1'b0,1'b0, "br_080");
    step(1'b1,1'b0,1'b1,9'h100,1'b0,1'b0, 9'h080,1'b1,1'b1,1'b1,1'b0, "flush_080_ign");
    step(1'b1,1'b0,1'b1,9'h100,1'b0,1'b0, 9'h081,1'b1,1'b1,1'b1,1'b0, "flush_081_ign");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h082,1'b1,1'b1,1'b0,1'b0, "run_082");
    // get to 0x020, then a 3-cycle stall
    step(1'b1,1'b0,1'b1,9'h01E,1'b0,1'b0, 9'h083,1'b1,1'b1,1'b0,1'b0, "br_01e");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h01E,1'b1,1'b1,1'b1,1'b0, "flush_01e");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h01F,1'b1,1'b1,1'b1,1'b0, "flush_01f");
    step(1'b1,1'b1,1'b0,9'h000,1'b0,1'b0, 9'h020,1'b1,1'b0,1'b0,1'b0, "stall_a");
    step(1'b1,1'b1,1'b0,9'h000,1'b0,1'b0, 9'h020,1'b1,1'b0,1'b0,1'b0, "stall_b");
    step(1'b1,1'b1,1'b0,9'h000,1'b0,1'b0, 9'h020,1'b1,1'b0,1'b0,1'b0, "stall_c");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h020,1'b1,1'b1,1'b0,1'b0, "stall_end");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h021,1'b1,1'b1,1'b0,1'b0, "run_021");
    // branch plus stall: redirect wins; stall inside FLUSH holds the PC
    step(1'b1,1'b1,1'b1,9'h030,1'b0,1'b0, 9'h022,1'b1,1'b0,1'b0,1'b0, "br_stall");
    step(1'b1,1'b1,1'b0,9'h000,1'b0,1'b0, 9'h030,1'b1,1'b0,1'b1,1'b0, "flush_stall");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h030,1'b1,1'b1,1'b1,1'b0, "flush_030");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h031,1'b1,1'b1,1'b0,1'b0, "run_031");
    // branch plus halt: redirect, flush, then halt, then resume
    step(1'b1,1'b0,1'b1,9'h040,1'b1,1'b0, 9'h032,1'b1,1'b1,1'b0,1'b0, "br_halt");
    step(1'b1,1'b0,1'b0,9'h000,1'b1,1'b0, 9'h040,1'b1,1'b1,1'b1,1'b0, "flush_040");
    step(1'b1,1'b0,1'b0,9'h000,1'b1,1'b0, 9'h041,1'b1,1'b1,1'b1,1'b0, "flush_041");
    step(1'b1,1'b0,1'b0,9'h000,1'b1,1'b0, 9'h042,1'b1,1'b1,1'b0,1'b0, "run_halt");
    step(1'b1,1'b1,1'b1,9'h100,1'b1,1'b0, 9'h042,1'b0,1'b0,1'b0,1'b1, "halted_ign");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b1, 9'h042,1'b0,1'b0,1'b0,1'b1, "resume");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b1, 9'h042,1'b1,1'b1,1'b0,1'b0, "run_042");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h043,1'b1,1'b1,1'b0,1'b0, "run_043");
    // reset in the middle of FLUSH, no redirect carried across
    step(1'b1,1'b0,1'b1,9'h100,1'b0,1'b0, 9'h044,1'b1,1'b1,1'b0,1'b0, "br_100");
    step(1'b0,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h000,1'b0,1'b0,1'b0,1'b0, "reset_flush");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h000,1'b0,1'b0,1'b0,1'b0, "reboot");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h000,1'b1,1'b1,1'b0,1'b0, "rerun0");
    step(1'b1,1'b0,1'b0,9'h000,1'b0,1'b0, 9'h001,1'b1,1'b1,1'b0,1'b0, "rerun1");

    @(negedge clk);
    #4;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
